// File: rtl/ctrl_states_pkg.sv
// rtl/ctrl_states_pkg.sv - shared state codes for ctrl_sequencer and controllogic
package ctrl_states_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] S_IDLE      = 5'd0;
    localparam logic [STATE_W-1:0] S_INIT1     = 5'd1;
    localparam logic [STATE_W-1:0] S_INIT2     = 5'd2;
    localparam logic [STATE_W-1:0] S_INIT3     = 5'd3;
    localparam logic [STATE_W-1:0] S_INIT4     = 5'd4;
    localparam logic [STATE_W-1:0] S_CHECK1    = 5'd5;
    localparam logic [STATE_W-1:0] S_CHECK2    = 5'd6;
    localparam logic [STATE_W-1:0] S_CHECK3    = 5'd7;
    localparam logic [STATE_W-1:0] S_CHECK4    = 5'd8;
    localparam logic [STATE_W-1:0] S_CHECK5    = 5'd9;
    localparam logic [STATE_W-1:0] S_CHECK6    = 5'd10;
    localparam logic [STATE_W-1:0] S_CHECK7    = 5'd11;
    localparam logic [STATE_W-1:0] S_CHECK8    = 5'd12;
    localparam logic [STATE_W-1:0] S_EXCHANGE1 = 5'd13;
    localparam logic [STATE_W-1:0] S_EXCHANGE2 = 5'd14;
    localparam logic [STATE_W-1:0] S_EXCHANGE3 = 5'd15;
    localparam logic [STATE_W-1:0] S_PRELOOP1  = 5'd16;
    localparam logic [STATE_W-1:0] S_PRELOOP2  = 5'd17;
    localparam logic [STATE_W-1:0] S_LOOP1     = 5'd18;
    localparam logic [STATE_W-1:0] S_LOOP2     = 5'd19;
    localparam logic [STATE_W-1:0] S_LOOP3     = 5'd20;
    localparam logic [STATE_W-1:0] S_LOOP4     = 5'd21;
    localparam logic [STATE_W-1:0] S_LOOP5     = 5'd22;
    localparam logic [STATE_W-1:0] S_LOOP6     = 5'd23;
    localparam logic [STATE_W-1:0] S_LOOP7     = 5'd24;
    localparam logic [STATE_W-1:0] S_LOOP8     = 5'd25;
    localparam logic [STATE_W-1:0] S_LOOP9     = 5'd26;
    localparam logic [STATE_W-1:0] S_LOOP10    = 5'd27;
    localparam logic [STATE_W-1:0] S_LOOP11    = 5'd28;
    localparam logic [STATE_W-1:0] S_END1      = 5'd29;
    localparam logic [STATE_W-1:0] S_END2      = 5'd30;
    localparam logic [STATE_W-1:0] S_UNUSED1   = 5'd31;

endpackage

// File: rtl/div_wait_counter.sv
// rtl/div_wait_counter.sv - loadable down-counter timing the divider hold
module div_wait_counter #(
    parameter int DIV_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    // Loaded on entry to the hold state, so the hold lasts DIV_LAT cycles.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load takes priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - next-state sequencer for the matrix-processing datapath
module ctrl_sequencer
    import ctrl_states_pkg::*;
#(
    parameter int DIV_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flag_z,
    input  logic               flag_s,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               done,
    output logic               err
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               done_q;
    logic               done_d;
    logic               err_q;
    logic               err_d;
    logic               cnt_load;
    logic               cnt_en;
    logic               cnt_zero;

    div_wait_counter #(
        .DIV_LAT (DIV_LAT)
    ) u_div_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .en    (cnt_en),
        .zero  (cnt_zero)
    );

    // State, done and err registers; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state: branches on flags only in the decision states, otherwise step to the next code.
    always_comb begin
        state_d = state_q + STATE_W'(1);
        case (state_q)
            S_IDLE:    state_d = start ? S_INIT1 : S_IDLE;
            S_CHECK4:  state_d = flag_z ? S_CHECK5 : S_PRELOOP1;
            S_CHECK7:  state_d = flag_z ? S_CHECK8 : S_EXCHANGE1;
            S_CHECK8:  state_d = flag_s ? S_CHECK5 : S_END1;
            S_LOOP5:   state_d = cnt_zero ? S_LOOP6 : S_LOOP5;
            S_LOOP11: begin
                if (flag_s) begin
                    state_d = S_LOOP1;
                end else if (flag_z) begin
                    state_d = S_END1;
                end else begin
                    state_d = S_CHECK1;
                end
            end
            S_END2:    state_d = S_IDLE;
            S_UNUSED1: state_d = S_IDLE;
            default:   state_d = state_q + STATE_W'(1);
        endcase
    end

    // Outputs and side effects decoded from the current state.
    always_comb begin
        busy     = (state_q != S_IDLE);
        done_d   = (state_q == S_END2);
        cnt_load = (state_q == S_LOOP4);
        cnt_en   = (state_q == S_LOOP5);
        err_d    = err_q;
        if ((state_q == S_IDLE) && start) begin
            err_d = 1'b0;
        end else if ((state_q == S_CHECK8) && !flag_s) begin
            err_d = 1'b1;
        end
    end

    assign state = state_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;
    import ctrl_states_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       flag_z;
    logic       flag_s;
    logic [4:0] st;
    logic       busy;
    logic       done;
    logic       err;

    logic       start1;
    logic       flag_z1;
    logic       flag_s1;
    logic [4:0] st1;
    logic       busy1;
    logic       done1;
    logic       err1;

    int n_assert;
    int n_fail;

    ctrl_sequencer #(.DIV_LAT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flag_z (flag_z),
        .flag_s (flag_s),
        .state  (st),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    ctrl_sequencer #(.DIV_LAT(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .flag_z (flag_z1),
        .flag_s (flag_s1),
        .state  (st1),
        .busy   (busy1),
        .done   (done1),
        .err    (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_to(input logic [4:0] tgt);
        int k;
        k = 0;
        while ((st !== tgt) && (k < 200)) begin
            tick();
            k++;
        end
        check("run_to", {27'd0, st}, {27'd0, tgt});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int clean_seq [26];
    int xchg_seq  [8];
    int cyc;
    int hold;

    initial begin
        clean_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 16, 17, 18, 19, 20, 21,
                      22, 22, 22, 22, 23, 24, 25, 26, 27, 28, 29, 30};
        xchg_seq  = '{8, 9, 10, 11, 13, 14, 15, 16};
        n_assert = 0;
        n_fail   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        flag_z  = 1'b0;
        flag_s  = 1'b0;
        start1  = 1'b0;
        flag_z1 = 1'b0;
        flag_s1 = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_state", {27'd0, st}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", {27'd0, st}, 32'd0);

        // Clean run: every state INIT1..END2, then the done cycle
        pulse_start();
        check("clean_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 26; i++) begin
            check("clean_seq", {27'd0, st}, clean_seq[i]);
            check("clean_nodone", {31'd0, done}, 32'd0);
            if (st == S_LOOP11) flag_z = 1'b1;
            tick();
        end
        check("clean_idle", {27'd0, st}, 32'd0);
        check("clean_done", {31'd0, done}, 32'd1);
        check("clean_busy0", {31'd0, busy}, 32'd0);
        check("clean_err", {31'd0, err}, 32'd0);
        // start in the done cycle is accepted
        flag_z = 1'b0;
        pulse_start();
        check("done_start", {27'd0, st}, {27'd0, S_INIT1});
        check("done_width", {31'd0, done}, 32'd0);

        // Reset mid-run in LOOP3
        run_to(S_LOOP3);
        rst_n = 1'b0;
        tick();
        check("midrst_state", {27'd0, st}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Exchange path
        flag_z = 1'b1;
        flag_s = 1'b0;
        pulse_start();
        run_to(S_CHECK4);
        for (int i = 0; i < 8; i++) begin
            check("xchg_seq", {27'd0, st}, xchg_seq[i]);
            if (st == S_CHECK7) flag_z = 1'b0;
            tick();
        end
        check("xchg_err", {31'd0, err}, 32'd0);
        run_to(S_LOOP11);
        flag_z = 1'b1;
        tick();
        check("xchg_end", {27'd0, st}, {27'd0, S_END1});
        run_to(S_IDLE);
        check("xchg_done", {31'd0, done}, 32'd1);

        // Singular matrix: two CHECK5-8 passes then END1 with err
        flag_z = 1'b1;
        flag_s = 1'b1;
        pulse_start();
        run_to(S_CHECK8);
        check("sing_err0", {31'd0, err}, 32'd0);
        tick();
        check("sing_retry", {27'd0, st}, {27'd0, S_CHECK5});
        flag_s = 1'b0;
        run_to(S_CHECK8);
        tick();
        check("sing_end", {27'd0, st}, {27'd0, S_END1});
        check("sing_err1", {31'd0, err}, 32'd1);
        run_to(S_IDLE);
        check("sing_done", {31'd0, done}, 32'd1);
        check("sing_err_idle", {31'd0, err}, 32'd1);
        tick();
        check("sing_done_off", {31'd0, done}, 32'd0);
        check("sing_err_hold", {31'd0, err}, 32'd1);

        // Illegal code returns to IDLE with no done and err unchanged
        force dut.state_q = 5'b11111;
        #1;
        release dut.state_q;
        check("ill_state", {27'd0, st}, 32'd31);
        check("ill_busy", {31'd0, busy}, 32'd1);
        tick();
        check("ill_idle", {27'd0, st}, 32'd0);
        check("ill_done", {31'd0, done}, 32'd0);
        check("ill_err", {31'd0, err}, 32'd1);

        // Next accepted start clears err
        flag_z = 1'b0;
        pulse_start();
        check("err_clr_state", {27'd0, st}, {27'd0, S_INIT1});
        check("err_clr", {31'd0, err}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Loop branching and ignored start
        flag_z = 1'b0;
        flag_s = 1'b1;
        pulse_start();
        run_to(S_LOOP11);
        tick();
        check("loop_s1", {27'd0, st}, {27'd0, S_LOOP1});
        flag_s = 1'b0;
        run_to(S_LOOP11);
        tick();
        check("loop_next_col", {27'd0, st}, {27'd0, S_CHECK1});
        run_to(S_LOOP7);
        pulse_start();
        check("ign_start", {27'd0, st}, {27'd0, S_LOOP8});
        run_to(S_LOOP11);
        flag_z = 1'b1;
        tick();
        check("loop_end", {27'd0, st}, {27'd0, S_END1});
        run_to(S_IDLE);
        check("loop_done", {31'd0, done}, 32'd1);

        // DIV_LAT=1 holds LOOP5 exactly one cycle
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 0;
        while ((st1 !== S_LOOP5) && (cyc < 100)) begin
            tick();
            cyc++;
        end
        check("lat1_reach", {27'd0, st1}, {27'd0, S_LOOP5});
        hold = 0;
        while ((st1 === S_LOOP5) && (hold < 20)) begin
            tick();
            hold++;
        end
        check("lat1_hold", hold, 32'd1);
        check("lat1_next", {27'd0, st1}, {27'd0, S_LOOP6});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
